// File: rtl/fetch_align_buffer.sv
// Instruction-fetch front end: issues word reads, queues halfwords and frames one instruction per handshake.
// Compressed (16-bit) support is enabled by defining RVC_EN; the default build handles 32-bit instructions only.
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    localparam logic [1:0] F_IDLE    = 2'd0;
    localparam logic [1:0] F_WAIT    = 2'd1;
    localparam logic [1:0] F_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] q_q [4];
    logic [15:0] q_d [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic        skip_lo_q, skip_lo_d;

    logic [15:0] hw0_s, hw1_s;
    logic        is16_s;
    logic [2:0]  need_s;
    logic        pop_s;
    logic        take_s;
    logic [1:0]  wr_ptr_s;
    logic [2:0]  push_n_s, pop_n_s;
    logic        unused_s;

    assign hw0_s = q_q[rd_ptr_q];
    assign hw1_s = q_q[rd_ptr_q + 2'd1];

`ifdef RVC_EN
    assign is16_s   = (hw0_s[1:0] != 2'b11);
    assign unused_s = flush_pc[0];
`else
    // Without RVC every word is one instruction; low bits pass through for decode to flag.
    assign is16_s   = 1'b0;
    assign unused_s = ^flush_pc[1:0];
`endif

    assign need_s     = is16_s ? 3'd1 : 3'd2;
    assign inst_valid = !flush && (count_q >= need_s);
    assign pop_s      = inst_valid && inst_ready;
    assign take_s     = (state_q == F_WAIT) && imem_rvalid && !flush;
    assign wr_ptr_s   = rd_ptr_q + count_q[1:0];

    // Free-slot check uses registered count only, keeping inst_ready off the request path.
    assign imem_req  = rst_n && !flush && (state_q == F_IDLE) && (count_q <= 3'd2);
    assign imem_addr = fetch_pc_q;
    assign inst_pc   = head_pc_q;
    assign inst_is_c = is16_s && (count_q != 3'd0);

    // Instruction framing from the queue head.
    always_comb begin
        inst = 32'h0000_0000;
        if (count_q == 3'd0) begin
            inst = 32'h0000_0000;
        end else if (is16_s) begin
            inst = {16'h0000, hw0_s};
        end else begin
            inst = {hw1_s, hw0_s};
        end
    end

    // Next-state: fetch FSM, queue writes/pops, PC tracking and flush redirect.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        skip_lo_d  = skip_lo_q;
        push_n_s   = 3'd0;
        pop_n_s    = 3'd0;

        case (state_q)
            F_IDLE: begin
                if (imem_req) state_d = F_WAIT;
                else          state_d = F_IDLE;
            end
            F_WAIT: begin
                if (imem_rvalid) state_d = F_IDLE;
                else if (flush)  state_d = F_DISCARD;
                else             state_d = F_WAIT;
            end
            F_DISCARD: begin
                if (imem_rvalid) state_d = F_IDLE;
                else             state_d = F_DISCARD;
            end
            default: state_d = F_IDLE;
        endcase

        if (flush) begin
            count_d    = 3'd0;
            rd_ptr_d   = 2'd0;
            fetch_pc_d = {flush_pc[31:2], 2'b00};
`ifdef RVC_EN
            head_pc_d  = {flush_pc[31:1], 1'b0};
            skip_lo_d  = flush_pc[1];
`else
            head_pc_d  = {flush_pc[31:2], 2'b00};
            skip_lo_d  = 1'b0;
`endif
        end else begin
            if (take_s) begin
                if (skip_lo_q) begin
                    q_d[wr_ptr_s] = imem_rdata[31:16];
                    push_n_s      = 3'd1;
                end else begin
                    q_d[wr_ptr_s]         = imem_rdata[15:0];
                    q_d[wr_ptr_s + 2'd1]  = imem_rdata[31:16];
                    push_n_s              = 3'd2;
                end
                skip_lo_d  = 1'b0;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                push_n_s = 3'd0;
            end
            if (pop_s) begin
                pop_n_s   = need_s;
                rd_ptr_d  = rd_ptr_q + need_s[1:0];
                head_pc_d = head_pc_q + (is16_s ? 32'd2 : 32'd4);
            end else begin
                pop_n_s = 3'd0;
            end
            count_d = count_q + push_n_s - pop_n_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_IDLE;
            for (int i = 0; i < 4; i++) q_q[i] <= 16'h0000;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            head_pc_q  <= {RESET_PC[31:1], 1'b0};
`ifdef RVC_EN
            skip_lo_q  <= RESET_PC[1];
`else
            skip_lo_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            skip_lo_q  <= skip_lo_d;
        end
    end

endmodule
